nx_node_ctrl: RTL and testbench
===============================

Name: nx_node_ctrl

Overview:
Control block of one Nexus mesh node; sits between the mesh message fabric, the node's logic core and its output-mapping store.
- Holds the core input state and applies combinational/sequential signal updates.
- Triggers the core.
- Detects core output changes, looks up each output's target in the store and emits signal-state messages while holding the channel token.

Parameters:
STREAM_WIDTH 32 message width
ADDR_ROW_WIDTH 4 row address width
ADDR_COL_WIDTH 4 column address width
COMMAND_WIDTH 2 message command field width
INPUTS 8 core inputs
OUTPUTS 8 core outputs
OP_STORE_LENGTH 256 store rows
OP_STORE_WIDTH 1+ADDR_ROW_WIDTH+ADDR_COL_WIDTH+$clog2(INPUTS)+1 store entry width

Ports:
clk_i in 1 clock
rst_i in 1 reset, synchronous, active-high
idle_o out 1 no activity pending
node_row_i/node_col_i in ADDR_ROW_WIDTH/ADDR_COL_WIDTH own address
trigger_i in 1 external trigger pulse
token_grant_i in 1 one-cycle token grant pulse
token_release_o out 1 one-cycle token release pulse
msg_data_o out STREAM_WIDTH message; msg_dir_o out 2 direction; msg_valid_o out 1; msg_ready_i in 1
map_idx_i in $clog2(OUTPUTS) output to configure; map_tgt_row_i/map_tgt_col_i/map_tgt_idx_i/map_tgt_seq_i in row/col/$clog2(INPUTS)/1 target; map_valid_i in 1
signal_index_i in $clog2(OUTPUTS) input index; signal_is_seq_i in 1; signal_state_i in 1; signal_valid_i in 1
core_trigger_o out 1; core_inputs_o out INPUTS; core_outputs_i in OUTPUTS
store_addr_o out $clog2(OP_STORE_LENGTH); store_wr_data_o out OP_STORE_WIDTH; store_wr_en_o out 1; store_rd_en_o out 1; store_rd_data_i in OP_STORE_WIDTH

Behaviour:
- Reset: every output 0 except idle_o=1; current inputs, next inputs and sent-output registers all cleared; FSM to IDLE.
- Store entry layout, MSB first: {valid=1, row, col, idx, seq}.
- map_valid_i: store_wr_en_o=1 combinationally; store_addr_o=map_idx_i zero-extended.
- Write has priority over read. A colliding read is retried on the next cycle.
- Signal update, signal_valid_i=1:
  - is_seq=0: current[index] <= state next cycle.
  - is_seq=1: next[index] <= state.
  - Index >= INPUTS is ignored.
- Trigger: trigger_i at cycle N gives current <= next, plus a one-cycle pulse on core_trigger_o at N+1. core_inputs_o always reflects current.
- Pending outputs = core_outputs_i XOR sent.
- FSM states: IDLE, LOOKUP, WAIT, SEND, RELEASE.
  - IDLE + token_grant_i: if pending is 0, go to RELEASE; else go to LOOKUP.
  - LOOKUP: store_rd_en_o=1 with addr = lowest pending index. Read data arrives next cycle (WAIT).
  - SEND, entry valid: hold msg_valid_o with stable data/dir until msg_ready_i, then sent[idx] <= core_outputs_i[idx].
  - SEND, entry invalid (valid bit 0): update sent only, no message.
  - After SEND: go to LOOKUP if pending is still nonzero, else RELEASE.
  - RELEASE: one-cycle token_release_o, then IDLE.
- Token: token_grant_i while not in IDLE is ignored.
- Message packing, MSB first: row, col, command=2'b01 (signal state), idx, seq, state; remaining LSBs 0.
- Direction, row comparison first:
  - tgt row < own row: 0 (north); tgt row > own row: 2 (south).
  - Rows equal: tgt col > own col: 1 (east); tgt col < own col: 3 (west).
  - Target equal to self: 2.
- idle_o = FSM in IDLE, pending=0, no trigger in flight.

Optional Feature:
NX_NODE_CTRL_LOOPBACK_EN
- Defined: a self-targeted entry emits no message; it is applied locally as a signal update (seq selects next or current) in SEND and completes in one cycle.
- Undefined: a self-targeted entry is sent on direction 2 like any other message.

Test Plan:
- Reset -> idle_o=1, all other outputs 0; token grant with core_outputs_i=0 -> token_release_o pulses 1 cycle later, no msg_valid_o.
- map_idx=3, tgt row 2, col 5, idx 4, seq 1 -> store_wr_en_o=1, addr 3, wr_data={1,2,5,4,1}.
- signal idx 2, seq=1, state 1, then trigger_i -> core_inputs_o[2] rises only with core_trigger_o pulse; seq=0 updates the next cycle.
- core_outputs_i=8'h08, entry 3 valid, node (1,1), grant -> rd at addr 3, msg to row 2 col 5, dir 2, idx 4, seq 1, state 1, then release.
- msg_ready_i low for 5 cycles -> msg_valid_o/data held stable; release only after handshake.
- Outputs 0 and 5 change with entry 0 invalid -> single message for 5; sent updated for both.

Source files
------------

// File: rtl/nx_node_ctrl.sv
// nx_node_ctrl: control block of one Nexus mesh node.
// Holds the logic core's input state, applies signal updates from the fabric,
// triggers the core, and while holding the channel token walks every changed
// core output, looks up its target in the output-mapping store and emits a
// signal-state message for it.
// Optional build macro NX_NODE_CTRL_LOOPBACK_EN: when defined, store entries that
// target this node itself are applied locally as a signal update instead of
// being sent out on the fabric.
module nx_node_ctrl #(
  parameter int STREAM_WIDTH    = 32,
  parameter int ADDR_ROW_WIDTH  = 4,
  parameter int ADDR_COL_WIDTH  = 4,
  parameter int COMMAND_WIDTH   = 2,
  parameter int INPUTS          = 8,
  parameter int OUTPUTS         = 8,
  parameter int OP_STORE_LENGTH = 256,
  parameter int OP_STORE_WIDTH  = 1 + ADDR_ROW_WIDTH + ADDR_COL_WIDTH + $clog2(INPUTS) + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  output logic                               idle_o,
  input  logic [ADDR_ROW_WIDTH-1:0]          node_row_i,
  input  logic [ADDR_COL_WIDTH-1:0]          node_col_i,
  input  logic                               trigger_i,
  input  logic                               token_grant_i,
  output logic                               token_release_o,
  output logic [STREAM_WIDTH-1:0]            msg_data_o,
  output logic [1:0]                         msg_dir_o,
  output logic                               msg_valid_o,
  input  logic                               msg_ready_i,
  input  logic [$clog2(OUTPUTS)-1:0]         map_idx_i,
  input  logic [ADDR_ROW_WIDTH-1:0]          map_tgt_row_i,
  input  logic [ADDR_COL_WIDTH-1:0]          map_tgt_col_i,
  input  logic [$clog2(INPUTS)-1:0]          map_tgt_idx_i,
  input  logic                               map_tgt_seq_i,
  input  logic                               map_valid_i,
  input  logic [$clog2(OUTPUTS)-1:0]         signal_index_i,
  input  logic                               signal_is_seq_i,
  input  logic                               signal_state_i,
  input  logic                               signal_valid_i,
  output logic                               core_trigger_o,
  output logic [INPUTS-1:0]                  core_inputs_o,
  input  logic [OUTPUTS-1:0]                 core_outputs_i,
  output logic [$clog2(OP_STORE_LENGTH)-1:0] store_addr_o,
  output logic [OP_STORE_WIDTH-1:0]          store_wr_data_o,
  output logic                               store_wr_en_o,
  output logic                               store_rd_en_o,
  input  logic [OP_STORE_WIDTH-1:0]          store_rd_data_i
);

  localparam int IN_IDX_W  = $clog2(INPUTS);
  localparam int OUT_IDX_W = $clog2(OUTPUTS);
  localparam int STORE_AW  = $clog2(OP_STORE_LENGTH);
  localparam int MSG_USED  = ADDR_ROW_WIDTH + ADDR_COL_WIDTH + COMMAND_WIDTH + IN_IDX_W + 2;
  localparam logic [COMMAND_WIDTH-1:0] CMD_SIG_STATE = COMMAND_WIDTH'(1);

`ifdef NX_NODE_CTRL_LOOPBACK_EN
  localparam logic LOOPBACK_EN = 1'b1;
`else
  localparam logic LOOPBACK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WAIT,
    S_SEND,
    S_RELEASE
  } state_t;

  state_t               state_q, state_d;
  logic [INPUTS-1:0]    cur_in_q;
  logic [INPUTS-1:0]    nxt_in_q;
  logic [OUTPUTS-1:0]   sent_q;
  logic                 trig_q;

  // Lookup pipeline: index chosen in LOOKUP (p0), entry and output state
  // captured when the store answers (p1).
  logic [OUT_IDX_W-1:0]      out_idx_p0;
  logic [OP_STORE_WIDTH-1:0] entry_p1;
  logic                      state_bit_p1;

  logic [OUTPUTS-1:0]   pending;
  logic [OUTPUTS-1:0]   sent_after;
  logic [OUTPUTS-1:0]   pending_after;
  logic [OUT_IDX_W-1:0] low_idx;

  logic                      e_valid;
  logic [ADDR_ROW_WIDTH-1:0] e_row;
  logic [ADDR_COL_WIDTH-1:0] e_col;
  logic [IN_IDX_W-1:0]       e_idx;
  logic                      e_seq;
  logic                      self_tgt;
  logic                      lb_hit;
  logic                      send_msg;
  logic                      send_done;
  logic [1:0]                dir;

  assign pending = core_outputs_i ^ sent_q;

  assign e_valid = entry_p1[OP_STORE_WIDTH-1];
  assign e_row   = entry_p1[OP_STORE_WIDTH-2 -: ADDR_ROW_WIDTH];
  assign e_col   = entry_p1[OP_STORE_WIDTH-2-ADDR_ROW_WIDTH -: ADDR_COL_WIDTH];
  assign e_idx   = entry_p1[1 +: IN_IDX_W];
  assign e_seq   = entry_p1[0];

  assign self_tgt  = (e_row == node_row_i) && (e_col == node_col_i);
  assign lb_hit    = LOOPBACK_EN && e_valid && self_tgt;
  assign send_msg  = (state_q == S_SEND) && e_valid && !lb_hit;
  assign send_done = (state_q == S_SEND) && (!send_msg || msg_ready_i);

  // Pick the lowest-numbered output whose state differs from what was last sent.
  always_comb begin
    low_idx = '0;
    for (int i = OUTPUTS - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = OUT_IDX_W'(i);
    end
  end

  // Pending set as it will look once the output in flight is marked sent.
  always_comb begin
    sent_after             = sent_q;
    sent_after[out_idx_p0] = state_bit_p1;
    pending_after          = core_outputs_i ^ sent_after;
  end

  // Route toward the target: rows first, then columns; self falls to south.
  always_comb begin
    dir = 2'd2;
    if (e_row < node_row_i)      dir = 2'd0;
    else if (e_row > node_row_i) dir = 2'd2;
    else if (e_col > node_col_i) dir = 2'd1;
    else if (e_col < node_col_i) dir = 2'd3;
  end

  // Token FSM next state plus store/message/token strobes; store writes win.
  always_comb begin
    state_d         = state_q;
    store_addr_o    = '0;
    store_wr_data_o = '0;
    store_wr_en_o   = 1'b0;
    store_rd_en_o   = 1'b0;
    token_release_o = 1'b0;
    msg_valid_o     = 1'b0;
    if (map_valid_i) begin
      store_wr_en_o   = 1'b1;
      store_addr_o    = STORE_AW'(map_idx_i);
      store_wr_data_o = {1'b1, map_tgt_row_i, map_tgt_col_i, map_tgt_idx_i, map_tgt_seq_i};
    end
    case (state_q)
      S_IDLE: begin
        if (token_grant_i) state_d = (pending == '0) ? S_RELEASE : S_LOOKUP;
      end
      S_LOOKUP: begin
        if (pending == '0) begin
          state_d = S_RELEASE;
        end else if (!map_valid_i) begin
          store_rd_en_o = 1'b1;
          store_addr_o  = STORE_AW'(low_idx);
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        msg_valid_o = send_msg;
        if (send_done) state_d = (pending_after != '0) ? S_LOOKUP : S_RELEASE;
      end
      S_RELEASE: begin
        token_release_o = 1'b1;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, core input registers, sent record and trigger pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cur_in_q <= '0;
      nxt_in_q <= '0;
      sent_q   <= '0;
      trig_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trigger_i;
      if (trigger_i) cur_in_q <= nxt_in_q;
      // Record the state actually carried by the message, not a later value.
      if (send_done) sent_q[out_idx_p0] <= state_bit_p1;
      for (int i = 0; i < INPUTS; i++) begin
        if ((state_q == S_SEND) && lb_hit && (int'(e_idx) == i)) begin
          if (e_seq) nxt_in_q[i] <= state_bit_p1;
          else       cur_in_q[i] <= state_bit_p1;
        end
        if (signal_valid_i && (int'(signal_index_i) == i)) begin
          if (signal_is_seq_i) nxt_in_q[i] <= signal_state_i;
          else                 cur_in_q[i] <= signal_state_i;
        end
      end
    end
  end

  // ---- p0 -> p1: latch the looked-up index, then the store entry and output state
  always_ff @(posedge clk_i) begin
    if (state_q == S_LOOKUP && store_rd_en_o) out_idx_p0 <= low_idx;
    if (state_q == S_WAIT) begin
      entry_p1     <= store_rd_data_i;
      state_bit_p1 <= core_outputs_i[out_idx_p0];
    end
  end

  assign msg_data_o = send_msg
    ? {e_row, e_col, CMD_SIG_STATE, e_idx, e_seq, state_bit_p1, {(STREAM_WIDTH-MSG_USED){1'b0}}}
    : '0;
  assign msg_dir_o      = send_msg ? dir : 2'd0;
  assign core_inputs_o  = cur_in_q;
  assign core_trigger_o = trig_q;
  assign idle_o         = (state_q == S_IDLE) && (pending == '0) && !trigger_i && !trig_q;

endmodule

// File: tb/tb_nx_node_ctrl.sv
// Self-checking bench for nx_node_ctrl: a behavioural store model answers reads
// one cycle later, expected messages go into a scoreboard queue when a grant is
// issued and are popped as the DUT completes each handshake.
module tb_nx_node_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        idle_o;
  logic [3:0]  node_row_i, node_col_i;
  logic        trigger_i, token_grant_i, token_release_o;
  logic [31:0] msg_data_o;
  logic [1:0]  msg_dir_o;
  logic        msg_valid_o, msg_ready_i;
  logic [2:0]  map_idx_i;
  logic [3:0]  map_tgt_row_i, map_tgt_col_i;
  logic [2:0]  map_tgt_idx_i;
  logic        map_tgt_seq_i, map_valid_i;
  logic [2:0]  signal_index_i;
  logic        signal_is_seq_i, signal_state_i, signal_valid_i;
  logic        core_trigger_o;
  logic [7:0]  core_inputs_o, core_outputs_i;
  logic [7:0]  store_addr_o;
  logic [12:0] store_wr_data_o, store_rd_data_i;
  logic        store_wr_en_o, store_rd_en_o;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  dir;
  } exp_t;

  exp_t        sb[$];
  logic [12:0] mem [256];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_hs = 0;

  always #5 clk = ~clk;

  nx_node_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .idle_o(idle_o),
    .node_row_i(node_row_i), .node_col_i(node_col_i),
    .trigger_i(trigger_i), .token_grant_i(token_grant_i), .token_release_o(token_release_o),
    .msg_data_o(msg_data_o), .msg_dir_o(msg_dir_o), .msg_valid_o(msg_valid_o), .msg_ready_i(msg_ready_i),
    .map_idx_i(map_idx_i), .map_tgt_row_i(map_tgt_row_i), .map_tgt_col_i(map_tgt_col_i),
    .map_tgt_idx_i(map_tgt_idx_i), .map_tgt_seq_i(map_tgt_seq_i), .map_valid_i(map_valid_i),
    .signal_index_i(signal_index_i), .signal_is_seq_i(signal_is_seq_i),
    .signal_state_i(signal_state_i), .signal_valid_i(signal_valid_i),
    .core_trigger_o(core_trigger_o), .core_inputs_o(core_inputs_o), .core_outputs_i(core_outputs_i),
    .store_addr_o(store_addr_o), .store_wr_data_o(store_wr_data_o), .store_wr_en_o(store_wr_en_o),
    .store_rd_en_o(store_rd_en_o), .store_rd_data_i(store_rd_data_i)
  );

  // Output-mapping store: synchronous write, registered read
  always @(posedge clk) begin
    if (store_wr_en_o) mem[store_addr_o] <= store_wr_data_o;
    if (store_rd_en_o) store_rd_data_i <= mem[store_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_msg(input logic [3:0] r, input logic [3:0] c,
                                         input logic [2:0] i, input logic s, input logic st);
    return {r, c, 2'b01, i, s, st, 17'b0};
  endfunction

  task automatic push(input logic [31:0] d, input logic [1:0] dr);
    exp_t e;
    e.data = d;
    e.dir  = dr;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic map_wr(input logic [2:0] idx, input logic [3:0] r, input logic [3:0] c,
                        input logic [2:0] ti, input logic s);
    tick();
    map_idx_i = idx; map_tgt_row_i = r; map_tgt_col_i = c; map_tgt_idx_i = ti; map_tgt_seq_i = s;
    map_valid_i = 1'b1;
    #1;
    chk("map_wr_en", 32'(store_wr_en_o), 32'd1);
    chk("map_addr", 32'(store_addr_o), 32'(idx));
    chk("map_wr_data", 32'(store_wr_data_o), 32'({1'b1, r, c, ti, s}));
    tick();
    map_valid_i = 1'b0;
  endtask

  task automatic grant();
    tick();
    token_grant_i = 1'b1;
    tick();
    token_grant_i = 1'b0;
  endtask

  task automatic wait_release();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (token_release_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("release_seen", 32'(seen), 32'd1);
    tick();
    chk("release_one_cycle", 32'(token_release_o), 32'd0);
    chk("idle_after_release", 32'(idle_o), 32'd1);
  endtask

  // Message monitor: stability under back-pressure and scoreboard pop on handshake
  initial begin
    logic        prev_v, prev_r;
    logic [31:0] prev_d;
    logic [1:0]  prev_dir;
    exp_t        e;
    prev_v = 1'b0; prev_r = 1'b0; prev_d = '0; prev_dir = '0;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (prev_v && !prev_r && msg_valid_o) begin
          chk("hold_data", msg_data_o, prev_d);
          chk("hold_dir", 32'(msg_dir_o), 32'(prev_dir));
        end
        if (msg_valid_o && msg_ready_i) begin
          n_hs++;
          if (sb.size() == 0) begin
            chk("unexpected_msg", msg_data_o, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("msg_data", msg_data_o, e.data);
            chk("msg_dir", 32'(msg_dir_o), 32'(e.dir));
          end
        end
        prev_v = msg_valid_o; prev_r = msg_ready_i; prev_d = msg_data_o; prev_dir = msg_dir_o;
      end
    end
  end

  initial begin
    int hs0;
    logic seen;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    store_rd_data_i = '0;
    rst_i = 1'b1; node_row_i = 4'd1; node_col_i = 4'd1;
    trigger_i = 0; token_grant_i = 0; msg_ready_i = 0;
    map_idx_i = 0; map_tgt_row_i = 0; map_tgt_col_i = 0; map_tgt_idx_i = 0; map_tgt_seq_i = 0; map_valid_i = 0;
    signal_index_i = 0; signal_is_seq_i = 0; signal_state_i = 0; signal_valid_i = 0;
    core_outputs_i = 8'h00;
    repeat (3) tick();
    rst_i = 1'b0;
    #1;

    // Reset state
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_release", 32'(token_release_o), 32'd0);
    chk("rst_msg_valid", 32'(msg_valid_o), 32'd0);
    chk("rst_msg_data", msg_data_o, 32'd0);
    chk("rst_msg_dir", 32'(msg_dir_o), 32'd0);
    chk("rst_core_trig", 32'(core_trigger_o), 32'd0);
    chk("rst_core_in", 32'(core_inputs_o), 32'd0);
    chk("rst_store", 32'({store_addr_o, store_wr_data_o, store_wr_en_o, store_rd_en_o}), 32'd0);

    // Grant with nothing pending: immediate release
    grant();
    chk("empty_release", 32'(token_release_o), 32'd1);
    chk("empty_no_msg", 32'(msg_valid_o), 32'd0);
    tick();
    chk("empty_release_drop", 32'(token_release_o), 32'd0);
    chk("empty_idle", 32'(idle_o), 32'd1);

    // Store configuration
    map_wr(3'd3, 4'd2, 4'd5, 3'd4, 1'b1);
    map_wr(3'd1, 4'd1, 4'd3, 3'd2, 1'b0);
    map_wr(3'd2, 4'd1, 4'd0, 3'd0, 1'b1);
    map_wr(3'd5, 4'd0, 4'd3, 3'd1, 1'b0);
    map_wr(3'd7, 4'd1, 4'd1, 3'd7, 1'b0);

    // Sequential update waits for trigger; combinational update lands next cycle
    tick();
    signal_index_i = 3'd2; signal_is_seq_i = 1'b1; signal_state_i = 1'b1; signal_valid_i = 1'b1;
    tick();
    signal_valid_i = 1'b0;
    chk("seq_not_applied", 32'(core_inputs_o), 32'h00);
    trigger_i = 1'b1;
    #1;
    chk("trig_cycle_inputs", 32'(core_inputs_o), 32'h00);
    chk("trig_not_idle", 32'(idle_o), 32'd0);
    tick();
    trigger_i = 1'b0;
    #1;
    chk("core_trig_pulse", 32'(core_trigger_o), 32'd1);
    chk("seq_applied", 32'(core_inputs_o), 32'h04);
    tick();
    chk("core_trig_drop", 32'(core_trigger_o), 32'd0);
    chk("trig_idle", 32'(idle_o), 32'd1);
    signal_index_i = 3'd6; signal_is_seq_i = 1'b0; signal_state_i = 1'b1; signal_valid_i = 1'b1;
    tick();
    signal_valid_i = 1'b0;
    chk("comb_applied", 32'(core_inputs_o), 32'h44);

    // Output 3 changes: one message south to (2,5); store write collides with the read
    msg_ready_i = 1'b1;
    core_outputs_i = 8'h08;
    push(mk_msg(4'd2, 4'd5, 3'd4, 1'b1, 1'b1), 2'd2);
    grant();
    map_idx_i = 3'd4; map_tgt_row_i = 4'd3; map_tgt_col_i = 4'd3; map_tgt_idx_i = 3'd0; map_tgt_seq_i = 1'b0;
    map_valid_i = 1'b1;
    #1;
    chk("collide_wr_en", 32'(store_wr_en_o), 32'd1);
    chk("collide_rd_en", 32'(store_rd_en_o), 32'd0);
    chk("collide_addr", 32'(store_addr_o), 32'd4);
    tick();
    map_valid_i = 1'b0;
    #1;
    chk("retry_rd_en", 32'(store_rd_en_o), 32'd1);
    chk("retry_addr", 32'(store_addr_o), 32'd3);
    wait_release();

    // Back-pressure on output 1 (east): message held for 5 cycles
    msg_ready_i = 1'b0;
    core_outputs_i = 8'h0A;
    push(mk_msg(4'd1, 4'd3, 3'd2, 1'b0, 1'b1), 2'd1);
    grant();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (msg_valid_o) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("bp_valid_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_held", 32'(msg_valid_o), 32'd1);
      chk("bp_no_release", 32'(token_release_o), 32'd0);
    end
    msg_ready_i = 1'b1;
    wait_release();

    // Outputs 0 (invalid entry) and 5 change: only one message, both marked sent
    core_outputs_i = 8'h2B;
    push(mk_msg(4'd0, 4'd3, 3'd1, 1'b0, 1'b1), 2'd0);
    hs0 = n_hs;
    grant();
    wait_release();
    chk("invalid_single_msg", 32'(n_hs - hs0), 32'd1);

    // Outputs 2 (west) and 7 (self) rise
    core_outputs_i = 8'hAF;
    push(mk_msg(4'd1, 4'd0, 3'd0, 1'b1, 1'b1), 2'd3);
`ifndef NX_NODE_CTRL_LOOPBACK_EN
    push(mk_msg(4'd1, 4'd1, 3'd7, 1'b0, 1'b1), 2'd2);
`endif
    grant();
    wait_release();
`ifdef NX_NODE_CTRL_LOOPBACK_EN
    chk("loopback_set", 32'(core_inputs_o[7]), 32'd1);
`endif

    // Several outputs fall at once: lowest index first
    core_outputs_i = 8'h08;
    push(mk_msg(4'd1, 4'd3, 3'd2, 1'b0, 1'b0), 2'd1);
    push(mk_msg(4'd1, 4'd0, 3'd0, 1'b1, 1'b0), 2'd3);
    push(mk_msg(4'd0, 4'd3, 3'd1, 1'b0, 1'b0), 2'd0);
`ifndef NX_NODE_CTRL_LOOPBACK_EN
    push(mk_msg(4'd1, 4'd1, 3'd7, 1'b0, 1'b0), 2'd2);
`endif
    grant();
    wait_release();
`ifdef NX_NODE_CTRL_LOOPBACK_EN
    chk("loopback_clr", 32'(core_inputs_o[7]), 32'd0);
`endif

    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
